// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown sequencer.
// Holds the FSM state type and the active-low 7-segment glyphs (gfedcba bit order).
// Optional display output is enabled by defining COUNTDOWN_SEG_EN.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Active-low segments, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/countdown_sequencer_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern (gfedcba); non-decimal codes blank.
// Latency: purely combinational.
// Backpressure: none, pure function of the input digit.
module seg7_decoder
    import countdown_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Map each decimal digit to its glyph, anything else shows blank
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_sequencer.sv
// Start/pause/load sequencer for an N-bit down counter with a built-in prescaler.
// Latency: all outputs registered; start at edge E0 gives done high the cycle after E0+C*PRESCALE.
// Backpressure: none; input priority reset > load > pause > start. COUNTDOWN_SEG_EN adds led1/led2.
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int N        = 6,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] load_val,
    input  logic         load,
    input  logic         start,
    input  logic         pause,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done
`ifdef COUNTDOWN_SEG_EN
    ,
    output logic [6:0]   led1,
    output logic [6:0]   led2
`endif
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    state_t         state;
    logic [N-1:0]   reload;
    logic [PW-1:0]  presc;

    // Main sequencer: state, count, prescaler and registered busy/done
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '1;
            reload <= '1;
            presc  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // Load always parks the sequencer in IDLE with a fresh prescaler
                count  <= load_val;
                reload <= load_val;
                presc  <= '0;
                state  <= IDLE;
                busy   <= 1'b0;
            end else if (pause) begin
                // Pause wins over a tick in the same cycle; only meaningful in RUN
                if (state == RUN) begin
                    state <= PAUSE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (count == '0) begin
                                state <= DONE;
                                done  <= ~done;
                            end else begin
                                state <= RUN;
                                presc <= '0;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    RUN, PAUSE: begin
                        // A resume edge counts as a running cycle, so each
                        // cycle spent in PAUSE delays expiry by exactly one
                        if (state == RUN || start) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            if (presc == PMAX) begin
                                presc <= '0;
                                if (count != '0) begin
                                    count <= count - N'(1);
                                    if (count == N'(1)) begin
                                        state <= DONE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                end
                            end else begin
                                presc <= presc + PW'(1);
                            end
                        end
                    end
                    DONE: begin
                        if (start) begin
                            if (reload == '0) begin
                                // Re-expire immediately; suppressed if done was
                                // just high so the pulse never lasts two cycles
                                done <= ~done;
                            end else begin
                                count <= reload;
                                presc <= '0;
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef COUNTDOWN_SEG_EN
    logic [31:0] cnt_mod;
    logic [3:0]  tens;
    logic [3:0]  units;

    assign cnt_mod = 32'(count) % 32'd100;
    assign tens    = 4'(cnt_mod / 32'd10);
    assign units   = 4'(cnt_mod % 32'd10);

    seg7_decoder u_tens (
        .digit (tens),
        .seg   (led1)
    );

    seg7_decoder u_units (
        .digit (units),
        .seg   (led2)
    );
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer (N=6, PRESCALE=4).
// Directed scenarios plus randomized traffic against a cycle-budget model.
// Define COUNTDOWN_SEG_EN to also check the 7-segment outputs.
module tb_countdown_sequencer;

    localparam int N = 6;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] load_val;
    logic         load;
    logic         start;
    logic         pause;
    logic [N-1:0] count;
    logic         busy;
    logic         done;
`ifdef COUNTDOWN_SEG_EN
    logic [6:0]   led1;
    logic [6:0]   led2;
`endif

    countdown_sequencer #(.N(N), .PRESCALE(P)) dut (
        .clk      (clk),
        .reset    (reset),
        .load_val (load_val),
        .load     (load),
        .start    (start),
        .pause    (pause),
        .count    (count),
        .busy     (busy),
        .done     (done)
`ifdef COUNTDOWN_SEG_EN
        ,
        .led1     (led1),
        .led2     (led2)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a countdown is a budget of base*P running cycles.
    // mode: 0 idle, 1 running, 2 paused, 3 expired
    int m_mode, m_idle_cnt, m_reload, m_base, m_run, m_done;

    function automatic int m_count();
        if (m_mode == 0) return m_idle_cnt;
        if (m_mode == 3) return 0;
        return m_base - m_run / P;
    endfunction

    task automatic model_edge(input bit r, input bit l, input bit s, input bit p, input int v);
        int  prev_done;
        bit  adv;
        prev_done = m_done;
        m_done = 0;
        if (r) begin
            m_mode = 0; m_idle_cnt = 63; m_reload = 63; m_run = 0;
        end else if (l) begin
            m_mode = 0; m_idle_cnt = v; m_reload = v;
        end else if (p) begin
            if (m_mode == 1) m_mode = 2;
        end else begin
            adv = (m_mode == 1) || (m_mode == 2 && s);
            if (s && m_mode == 0) begin
                if (m_idle_cnt == 0) begin
                    m_mode = 3; m_done = (prev_done == 0);
                end else begin
                    m_mode = 1; m_base = m_idle_cnt; m_run = 0;
                end
            end else if (s && m_mode == 3) begin
                if (m_reload == 0) m_done = (prev_done == 0);
                else begin
                    m_mode = 1; m_base = m_reload; m_run = 0;
                end
            end
            if (adv) begin
                m_mode = 1;
                m_run++;
                if (m_run == m_base * P) begin
                    m_mode = 3; m_done = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge
    task automatic step(input bit r, input bit l, input bit s, input bit p, input int v);
        reset = r; load = l; start = s; pause = p; load_val = N'(v);
        @(posedge clk);
        model_edge(r, l, s, p, v);
        @(negedge clk);
        check("count", count, m_count());
        check("busy", busy, (m_mode == 1 || m_mode == 2) ? 1 : 0);
        check("done", done, m_done);
    endtask

    // Idle cycles until done is seen; k is the number of edges taken (limit on timeout)
    task automatic run_until_done(input int limit, output int k);
        k = limit;
        for (int i = 1; i <= limit; i++) begin
            step(0, 0, 0, 0, 0);
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    int k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; load = 0; start = 0; pause = 0; load_val = '0;
        m_mode = 0; m_idle_cnt = 63; m_reload = 63; m_base = 0; m_run = 0; m_done = 0;

        // Reset for two cycles
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_count", count, 63);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // Basic countdown: load 5, start, done 20 edges after start edge
        step(0, 1, 0, 0, 5);
        step(0, 0, 1, 0, 0);
        check("run_busy", busy, 1);
        run_until_done(40, k);
        check("basic_latency", k, 20);
        step(0, 0, 0, 0, 0);
        check("done_single", done, 0);
        check("done_busy_low", busy, 0);

        // Restart from DONE reloads 5
        step(0, 0, 1, 0, 0);
        check("rearm_count", count, 5);
        check("rearm_busy", busy, 1);
        run_until_done(40, k);
        check("rearm_latency", k, 20);

        // Pause at count 3 for 10 cycles, then resume
        step(0, 1, 0, 0, 5);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
        check("pre_pause_count", count, 3);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        check("paused_count", count, 3);
        check("paused_busy", busy, 1);
        step(0, 0, 1, 0, 0);
        run_until_done(40, k);
        check("resume_latency", 20 + k, 30);

        // Zero load then start expires at once
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        step(0, 1, 0, 0, 5);
        step(0, 0, 1, 0, 0);
        check("zero_rearm_count", count, 5);

        // Load with start in the same cycle: load wins, stays idle
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 9);
        check("loadstart_count", count, 9);
        check("loadstart_busy", busy, 0);

        // Reset mid-run
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("midrun_reset_count", count, 63);
        check("midrun_reset_busy", busy, 0);

`ifdef COUNTDOWN_SEG_EN
        step(0, 1, 0, 0, 37);
        check("led1_tens3", led1, 7'h30);
        check("led2_units7", led2, 7'h78);
`endif

        // Randomized traffic checked against the model each cycle
        for (int i = 0; i < 1500; i++) begin
            bit r, l, s, p;
            int v;
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 5) == 0);
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 4);
            step(r, l, s, p, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
